// File: rtl/pbvi_gamma_build.sv
// PBVI gamma_a_b builder: per-observation argmax of b.alpha, summed over observations plus reward.
// Latency: result valid 1 cycle after the in_last_o beat; input stalls (in_ready=0) while a result waits.
// Optional macro GAMMA_SAT_EN clamps each output component to 16'hFFFF instead of wrapping.
module pbvi_gamma_build #(
  parameter int NUM_O_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_g_s0,
  input  logic [15:0] in_g_s1,
  input  logic        in_last_v,
  input  logic        in_last_o,
  input  logic [1:0]  in_action,
  input  logic [15:0] b_s0,
  input  logic [15:0] b_s1,
  input  logic [15:0] r_s0,
  input  logic [15:0] r_s1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_g_s0,
  output logic [15:0] out_g_s1,
  output logic [1:0]  out_action
);

  localparam int ACC_W = 16 + $clog2(NUM_O_MAX);

  typedef enum logic {S_ACC, S_EMIT} state_t;
  state_t state, state_nxt;

  logic             grp_first;
  logic             obs_first;
  logic [15:0]      bl_s0, bl_s1, rl_s0, rl_s1;
  logic [1:0]       act_l;
  logic [15:0]      win_s0, win_s1;
  logic [32:0]      win_dot;
  logic [ACC_W-1:0] acc_s0, acc_s1;

  logic             beat, handoff, last_v_eff, take;
  logic [15:0]      eb_s0, eb_s1, er_s0, er_s1;
  logic [1:0]       e_act;
  logic [31:0]      prod0, prod1;
  logic [32:0]      dot, cur_dot;
  logic [15:0]      cur_s0, cur_s1;
  logic [ACC_W-1:0] acc_nxt_s0, acc_nxt_s1;
  logic [ACC_W:0]   sum_s0, sum_s1;

  function automatic logic [15:0] narrow(input logic [ACC_W:0] s);
`ifdef GAMMA_SAT_EN
    return (s > (ACC_W+1)'(17'h0FFFF)) ? 16'hFFFF : s[15:0];
`else
    return s[15:0];
`endif
  endfunction

  assign beat       = in_valid && in_ready;
  assign handoff    = out_valid && out_ready;
  assign last_v_eff = in_last_v || in_last_o;

  // The first beat of a group scores against the live belief, since it is latched on that same edge.
  assign eb_s0 = grp_first ? b_s0 : bl_s0;
  assign eb_s1 = grp_first ? b_s1 : bl_s1;
  assign er_s0 = grp_first ? r_s0 : rl_s0;
  assign er_s1 = grp_first ? r_s1 : rl_s1;
  assign e_act = grp_first ? in_action : act_l;

  assign prod0 = {16'd0, eb_s0} * {16'd0, in_g_s0};
  assign prod1 = {16'd0, eb_s1} * {16'd0, in_g_s1};
  assign dot   = {1'b0, prod0} + {1'b0, prod1};

  // Strict compare: ties keep the earlier vector.
  assign take    = obs_first || (dot > win_dot);
  assign cur_s0  = take ? in_g_s0 : win_s0;
  assign cur_s1  = take ? in_g_s1 : win_s1;
  assign cur_dot = take ? dot : win_dot;

  assign acc_nxt_s0 = acc_s0 + ACC_W'(cur_s0);
  assign acc_nxt_s1 = acc_s1 + ACC_W'(cur_s1);
  assign sum_s0     = (ACC_W+1)'(acc_nxt_s0) + (ACC_W+1)'(er_s0);
  assign sum_s1     = (ACC_W+1)'(acc_nxt_s1) + (ACC_W+1)'(er_s1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:   if (beat && in_last_o) state_nxt = S_EMIT;
      S_EMIT:  if (out_ready)         state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_ACC:   in_ready  = 1'b1;
      S_EMIT:  out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_first  <= 1'b1;
      obs_first  <= 1'b1;
      bl_s0      <= '0;
      bl_s1      <= '0;
      rl_s0      <= '0;
      rl_s1      <= '0;
      act_l      <= '0;
      win_s0     <= '0;
      win_s1     <= '0;
      win_dot    <= '0;
      acc_s0     <= '0;
      acc_s1     <= '0;
      out_g_s0   <= '0;
      out_g_s1   <= '0;
      out_action <= '0;
    end else begin
      if (beat) begin
        if (grp_first) begin
          bl_s0     <= b_s0;
          bl_s1     <= b_s1;
          rl_s0     <= r_s0;
          rl_s1     <= r_s1;
          act_l     <= in_action;
          grp_first <= 1'b0;
        end
        if (last_v_eff) begin
          acc_s0    <= acc_nxt_s0;
          acc_s1    <= acc_nxt_s1;
          obs_first <= 1'b1;
        end else begin
          win_s0    <= cur_s0;
          win_s1    <= cur_s1;
          win_dot   <= cur_dot;
          obs_first <= 1'b0;
        end
        if (in_last_o) begin
          out_g_s0   <= narrow(sum_s0);
          out_g_s1   <= narrow(sum_s1);
          out_action <= e_act;
        end
      end
      if (handoff) begin
        acc_s0    <= '0;
        acc_s1    <= '0;
        grp_first <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pbvi_gamma_build.sv
// Directed bench for pbvi_gamma_build: argmax/ties, latching, backpressure, overflow, reset mid-group.
`timescale 1ns/1ps
module tb_pbvi_gamma_build;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_g_s0, in_g_s1;
  logic        in_last_v, in_last_o;
  logic [1:0]  in_action;
  logic [15:0] b_s0, b_s1, r_s0, r_s1;
  logic        out_valid, out_ready;
  logic [15:0] out_g_s0, out_g_s1;
  logic [1:0]  out_action;

  int n_vec = 0;
  int n_err = 0;

  pbvi_gamma_build #(.NUM_O_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_g_s0(in_g_s0), .in_g_s1(in_g_s1),
    .in_last_v(in_last_v), .in_last_o(in_last_o), .in_action(in_action),
    .b_s0(b_s0), .b_s1(b_s1), .r_s0(r_s0), .r_s1(r_s1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_g_s0(out_g_s0), .out_g_s1(out_g_s1), .out_action(out_action)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setgrp(input logic [15:0] b0, b1, r0, r1, input logic [1:0] a);
    b_s0 = b0; b_s1 = b1; r_s0 = r0; r_s1 = r1; in_action = a;
  endtask

  task automatic beat(input logic [15:0] g0, g1, input logic lv, lo);
    int w;
    w = 0;
    in_g_s0 = g0; in_g_s1 = g1; in_last_v = lv; in_last_o = lo; in_valid = 1'b1;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w == 20) chk("in_ready_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last_v = 1'b0; in_last_o = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] e0, e1, input logic [1:0] ea);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_s0"}, out_g_s0, e0);
    chk({tag, "_s1"}, out_g_s1, e1);
    chk({tag, "_act"}, out_action, ea);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_g_s0 = '0; in_g_s1 = '0; in_last_v = 1'b0; in_last_o = 1'b0;
    setgrp(0, 0, 0, 0, 0);
    #1;
    chk("rst_vld", out_valid, 0);
    chk("rst_s0", out_g_s0, 0);
    chk("rst_s1", out_g_s1, 0);
    chk("rst_act", out_action, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", in_ready, 1);

    // Two observations; belief/reward/action scrambled after the first beat must be ignored.
    setgrp(3, 5, 10, 20, 2'b01);
    beat(1, 2, 0, 0);
    setgrp(1, 0, 999, 999, 2'b10);
    beat(4, 1, 0, 0);
    beat(2, 2, 1, 0);
    beat(0, 3, 0, 0);
    beat(5, 0, 0, 1);
    chk_out("basic", 14, 24, 2'b01);
    chk("basic_rdy", in_ready, 0);
    @(posedge clk); #1;
    chk("basic_done_vld", out_valid, 0);
    chk("basic_done_rdy", in_ready, 1);
    chk("basic_hold_s0", out_g_s0, 14);

    // Tie keeps the earlier vector; result held under backpressure.
    out_ready = 1'b0;
    setgrp(1, 1, 7, 9, 2'b10);
    beat(2, 3, 0, 0);
    beat(3, 2, 1, 1);
    chk_out("tie", 9, 12, 2'b10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rdy", in_ready, 0);
      chk("bp_vld", out_valid, 1);
      chk("bp_s0", out_g_s0, 9);
      chk("bp_s1", out_g_s1, 12);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_rdy", in_ready, 1);
    chk("bp_rel_vld", out_valid, 0);

    // Next group after backpressure: accumulators must start from zero.
    setgrp(2, 1, 0, 0, 2'b11);
    beat(1, 5, 0, 0);
    beat(3, 0, 1, 0);
    beat(2, 2, 1, 1);
    chk_out("after_bp", 3, 7, 2'b11);
    @(posedge clk); #1;

    // Overflow on s0.
    setgrp(1, 1, 16'hFFF0, 0, 2'b01);
    beat(16'h0020, 1, 1, 1);
`ifdef GAMMA_SAT_EN
    chk_out("ovf", 16'hFFFF, 1, 2'b01);
`else
    chk_out("ovf", 16'h0010, 1, 2'b01);
`endif
    @(posedge clk); #1;

    // Reset after 2 of 4 beats: partial result discarded.
    setgrp(1, 1, 5, 5, 2'b10);
    beat(100, 100, 1, 0);
    beat(50, 50, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_vld", out_valid, 0);
    chk("mrst_s0", out_g_s0, 0);
    chk("mrst_s1", out_g_s1, 0);
    chk("mrst_act", out_action, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst_rel_vld", out_valid, 0);
    chk("mrst_rel_rdy", in_ready, 1);
    setgrp(2, 2, 1, 1, 2'b11);
    beat(3, 4, 1, 1);
    chk_out("fresh", 4, 5, 2'b11);
    @(posedge clk); #1;
    chk("fresh_done_vld", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
